// File: rtl/l2_flatten.sv
// Flatten two 32x32 pooled L1 maps into interleaved L2 memory, L2[2*i+k] = L1_k[i].
// Latency: 3 cycles per element, 6*N_PIX+1 cycles from start to done. There is no backpressure; start is ignored while busy.
module l2_flatten #(
   parameter int         N_PIX  = 1024,
   parameter int         ADDR_W = 12,
   parameter int         DATA_W = 20,
   parameter logic [2:0] SEL_K0 = 3'b011,
   parameter logic [2:0] SEL_K1 = 3'b100,
   parameter logic [2:0] SEL_L2 = 3'b101
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DATA_W-1:0] cdata_wr,
   output logic [2:0]        csel
);

   localparam int               PIX_W    = $clog2(N_PIX);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIX - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t           state;
   logic [PIX_W-1:0] pix;
   logic             k;
   logic [PIX_W-1:0] pix_inc;

   assign pix_inc = pix + PIX_W'(1);

   // Strobes and addresses are loaded on the edge entering their state, so
   // they are stable for the whole RD/WR cycle; cdata_wr doubles as the data register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pix      <= '0;
         k        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         crd  <= 1'b0;
         cwr  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RD;
                  busy     <= 1'b1;
                  pix      <= '0;
                  k        <= 1'b0;
                  crd      <= 1'b1;
                  caddr_rd <= '0;
               end
            end
            RD: begin
               state <= CAP;
            end
            CAP: begin
               state    <= WR;
               cdata_wr <= cdata_rd;
               cwr      <= 1'b1;
               caddr_wr <= ADDR_W'({pix, k});
            end
            WR: begin
               if (!k) begin
                  k        <= 1'b1;
                  state    <= RD;
                  crd      <= 1'b1;
                  caddr_rd <= ADDR_W'(pix);
               end else if (pix != LAST_PIX) begin
                  k        <= 1'b0;
                  pix      <= pix_inc;
                  state    <= RD;
                  crd      <= 1'b1;
                  caddr_rd <= ADDR_W'(pix_inc);
               end else begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      csel = 3'b000;
      case (state)
         RD:      csel = k ? SEL_K1 : SEL_K0;
         WR:      csel = SEL_L2;
         default: csel = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_l2_flatten.sv
// Bench for l2_flatten: L1/L2 memory models, a write-order reference and per-scenario tasks.
module tb_l2_flatten;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [19:0] cdata_rd;
   logic        cwr;
   logic [11:0] caddr_wr;
   logic [19:0] cdata_wr;
   logic [2:0]  csel;

   l2_flatten dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .csel     (csel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [19:0] l1_0 [0:1023];
   logic [19:0] l1_1 [0:1023];
   logic [19:0] l2   [0:2047];
   bit          l2_vld [0:2047];

   int n_chk  = 0;
   int n_pass = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int rd_seq = 0;
   int wr_seq = 0;
   int seq_err = 0;
   int proto_err = 0;

   // Memories: read data valid only the cycle after crd, garbage otherwise
   always @(posedge clk) begin
      if (crd)
         cdata_rd <= (csel == 3'b100) ? l1_1[caddr_rd[9:0]] : l1_0[caddr_rd[9:0]];
      else
         cdata_rd <= 20'($urandom);
      if (reset) begin
         for (int i = 0; i < 2048; i++) l2_vld[i] <= 1'b0;
      end else if (cwr && csel == 3'b101) begin
         l2[caddr_wr[10:0]]     <= cdata_wr;
         l2_vld[caddr_wr[10:0]] <= 1'b1;
      end
   end

   // Reference: the n-th read of a pass fetches L1_(n%2)[n/2]; the n-th write lands at L2[n]
   always @(negedge clk) begin
      int          idx;
      logic [19:0] exp_d;
      if (reset) begin
         rd_seq = 0;
         wr_seq = 0;
      end else begin
         if (crd && cwr) proto_err++;
         if ((csel == 3'b101) != cwr) proto_err++;
         if (crd && csel != 3'b011 && csel != 3'b100) proto_err++;
         if (!crd && !cwr && csel != 3'b000) proto_err++;
         if (crd) begin
            idx = rd_seq % 2048;
            if (caddr_rd != 12'(idx / 2) || csel != ((idx % 2 == 1) ? 3'b100 : 3'b011)) seq_err++;
            rd_seq++;
            rd_cnt++;
         end
         if (cwr) begin
            idx   = wr_seq % 2048;
            exp_d = (idx % 2 == 1) ? l1_1[idx / 2] : l1_0[idx / 2];
            if (caddr_wr != 12'(idx) || cdata_wr != exp_d) seq_err++;
            wr_seq++;
            wr_cnt++;
         end
      end
   end

   int          first_crd_cyc, first_cwr_cyc, done_cyc, done_cnt, busy_low_cyc;
   logic        busy_c1;
   logic [11:0] first_rd_addr, first_wr_addr;
   logic [2:0]  first_rd_sel;
   logic [50:0] rst_snap;

   function automatic int l2_bad();
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (!l2_vld[2*i]   || l2[2*i]   !== l1_0[i]) bad++;
         if (!l2_vld[2*i+1] || l2[2*i+1] !== l1_1[i]) bad++;
      end
      return bad;
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 1024; i++) begin
         l1_0[i] = 20'($urandom);
         l1_1[i] = 20'($urandom);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Start at cycle 0; cycle numbers are counted from that pulse. Extra start
   // pulses go high in cycles e1/e2/e3; reset is raised mid-cycle rst_at.
   task automatic run_pass(input int e1, input int e2, input int e3, input int rst_at);
      first_crd_cyc = -1;
      first_cwr_cyc = -1;
      done_cyc      = -1;
      done_cnt      = 0;
      busy_low_cyc  = -1;
      busy_c1       = 1'b0;
      rst_snap      = '1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 7000; cyc++) begin
         if (crd && first_crd_cyc < 0) begin
            first_crd_cyc = cyc;
            first_rd_addr = caddr_rd;
            first_rd_sel  = csel;
         end
         if (cwr && first_cwr_cyc < 0) begin
            first_cwr_cyc = cyc;
            first_wr_addr = caddr_wr;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (cyc == 1) busy_c1 = busy;
         if (!busy && busy_low_cyc < 0 && cyc > 1) busy_low_cyc = cyc;
         if (cyc == rst_at) begin
            reset = 1'b1;
            #1;
            rst_snap = {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            break;
         end
         start = (cyc == e1 || cyc == e2 || cyc == e3);
         if (done_cyc > 0 && cyc >= done_cyc + 20) break;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int rd0, wr0;
      #1;
      n_chk++;
      if ({busy, done, crd, cwr} !== 4'b0000)
         $display("FAIL reset_strobes: got %b expected 0000", {busy, done, crd, cwr});
      else n_pass++;
      n_chk++;
      if (csel !== 3'b000) $display("FAIL reset_csel: got %b expected 000", csel);
      else n_pass++;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      n_chk++;
      if (rd_cnt - rd0 != 0 || wr_cnt - wr0 != 0 || busy !== 1'b0)
         $display("FAIL idle_no_access: got rd=%0d wr=%0d busy=%b expected 0 0 0",
                  rd_cnt - rd0, wr_cnt - wr0, busy);
      else n_pass++;
   endtask

   task automatic test_ordering();
      int rd0, wr0;
      for (int i = 0; i < 1024; i++) begin
         l1_0[i] = 20'(i);
         l1_1[i] = 20'h80000 | 20'(i);
      end
      do_reset();
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      run_pass(-1, -1, -1, -1);
      n_chk++;
      if (!l2_vld[0] || l2[0] !== 20'h00000) $display("FAIL l2_0: got %h expected 00000", l2[0]);
      else n_pass++;
      n_chk++;
      if (!l2_vld[1] || l2[1] !== 20'h80000) $display("FAIL l2_1: got %h expected 80000", l2[1]);
      else n_pass++;
      n_chk++;
      if (!l2_vld[2046] || l2[2046] !== 20'd1023) $display("FAIL l2_2046: got %h expected 003ff", l2[2046]);
      else n_pass++;
      n_chk++;
      if (!l2_vld[2047] || l2[2047] !== 20'h803FF) $display("FAIL l2_2047: got %h expected 803ff", l2[2047]);
      else n_pass++;
      n_chk++;
      if (l2_bad() != 0) $display("FAIL ramp_all: got %0d bad entries expected 0", l2_bad());
      else n_pass++;
      n_chk++;
      if (wr_cnt - wr0 != 2048) $display("FAIL write_count: got %0d expected 2048", wr_cnt - wr0);
      else n_pass++;
      n_chk++;
      if (rd_cnt - rd0 != 2048) $display("FAIL read_count: got %0d expected 2048", rd_cnt - rd0);
      else n_pass++;
   endtask

   task automatic test_timing();
      fill_rand();
      do_reset();
      run_pass(-1, -1, -1, -1);
      n_chk++;
      if (first_crd_cyc != 1 || first_rd_addr !== 12'd0 || first_rd_sel !== 3'b011)
         $display("FAIL first_read: got cyc=%0d addr=%0d sel=%b expected 1 0 011",
                  first_crd_cyc, first_rd_addr, first_rd_sel);
      else n_pass++;
      n_chk++;
      if (first_cwr_cyc != 3 || first_wr_addr !== 12'd0)
         $display("FAIL first_write: got cyc=%0d addr=%0d expected 3 0", first_cwr_cyc, first_wr_addr);
      else n_pass++;
      n_chk++;
      if (busy_c1 !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy_c1);
      else n_pass++;
      n_chk++;
      if (done_cyc != 6145) $display("FAIL done_cycle: got %0d expected 6145", done_cyc);
      else n_pass++;
      n_chk++;
      if (busy_low_cyc != 6146) $display("FAIL busy_fall: got %0d expected 6146", busy_low_cyc);
      else n_pass++;
      n_chk++;
      if (l2_bad() != 0) $display("FAIL rand_data: got %0d bad entries expected 0", l2_bad());
      else n_pass++;
   endtask

   task automatic test_busy_start();
      int rd0;
      fill_rand();
      do_reset();
      rd0 = rd_cnt;
      // 6145 is the FIN cycle: a start sampled on the FIN->IDLE edge must be dropped
      run_pass(100, 3000, 6145, -1);
      n_chk++;
      if (done_cnt != 1) $display("FAIL busy_start_done: got %0d pulses expected 1", done_cnt);
      else n_pass++;
      n_chk++;
      if (rd_cnt - rd0 != 2048 || busy !== 1'b0)
         $display("FAIL busy_start_single: got rd=%0d busy=%b expected 2048 0", rd_cnt - rd0, busy);
      else n_pass++;
      n_chk++;
      if (done_cyc != 6145) $display("FAIL busy_start_cycle: got %0d expected 6145", done_cyc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      fill_rand();
      run_pass(-1, -1, -1, -1);
      n_chk++;
      if (done_cyc != 6145 || done_cnt != 1)
         $display("FAIL b2b_done: got cyc=%0d pulses=%0d expected 6145 1", done_cyc, done_cnt);
      else n_pass++;
      n_chk++;
      if (l2_bad() != 0) $display("FAIL b2b_data: got %0d bad entries expected 0", l2_bad());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      fill_rand();
      do_reset();
      run_pass(-1, -1, -1, 2000);
      n_chk++;
      if (rst_snap !== '0) $display("FAIL async_reset_outputs: got %h expected 0", rst_snap);
      else n_pass++;
      fill_rand();
      run_pass(-1, -1, -1, -1);
      n_chk++;
      if (first_cwr_cyc != 3 || first_wr_addr !== 12'd0)
         $display("FAIL restart_first_write: got cyc=%0d addr=%0d expected 3 0", first_cwr_cyc, first_wr_addr);
      else n_pass++;
      n_chk++;
      if (done_cyc != 6145) $display("FAIL restart_done: got %0d expected 6145", done_cyc);
      else n_pass++;
      n_chk++;
      if (l2_bad() != 0) $display("FAIL restart_data: got %0d bad entries expected 0", l2_bad());
      else n_pass++;
   endtask

   task automatic test_protocol();
      n_chk++;
      if (proto_err != 0) $display("FAIL protocol: got %0d violations expected 0", proto_err);
      else n_pass++;
      n_chk++;
      if (seq_err != 0) $display("FAIL access_order: got %0d mismatches expected 0", seq_err);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      test_reset();
      test_ordering();
      test_timing();
      test_busy_start();
      test_back_to_back();
      test_reset_mid();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
